driver_switch: RTL and testbench
================================

Name: driver_switch

Overview:
- Memory-mapped input peripheral: the read-side counterpart of the LED/digital-tube output driver.
- Samples 32 board DIP switches and 8 user keys, synchronises and debounces them, and presents the results to the CPU.
- Latches key-press events in a pending register and raises an interrupt request.
- Sits on the same bridge/Addr[4:2] word-select bus as the other peripheral drivers; the CPU reads via RD and writes via DIn/WE.

Parameters:
- DEB_CYCLES, 200000, clk cycles per debounce sample tick (10 ms at 20 MHz). Must be >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- DIn  input  32  CPU write data.
- WE  input  1  CPU write enable, sampled on rising clk.
- Addr  input  3 ([4:2])  word select within the block.
- RD  output  32  CPU read data, combinational from Addr and registers.
- sw_n  input  32  raw DIP switches, active-low (0 = switch on), asynchronous.
- key  input  8  raw user keys, active-high (1 = pressed), asynchronous.
- irq  output  1  interrupt request, level, active-high.

Behaviour:
- Reset (reset=0, async):
  - All registers cleared: sync stages, sample regs, stable_sw, stable_key, pending, ien, tick counter.
  - Therefore RD=0 for every Addr and irq=0.
- Synchroniser: two flops on each of the 40 inputs. sw_n is inverted after synchronisation, so stored/read 1 = switch on.
- Tick counter:
  - Counts 0..DEB_CYCLES-1, then wraps to 0.
  - tick=1 for the one cycle in which the count equals DEB_CYCLES-1.
- Debounce, per bit, evaluated only on tick:
  - samp <= sync.
  - If sync == samp (unchanged across two consecutive ticks), stable <= sync; otherwise stable holds.
  - A clean input change appears in stable on the 2nd tick after it leaves the synchroniser. Change-to-visible latency is <= 2*DEB_CYCLES+3 cycles.
  - A glitch shorter than one tick period never reaches stable.
- Key edge detect:
  - prev_key <= stable_key every cycle.
  - pending[i] is set when stable_key[i]=1 and prev_key[i]=0 (a press); release does not set it.
- Register map (word index = Addr[4:2]):
  - 0: R  stable_sw[31:0].
  - 1: R  {24'b0, stable_key}.
  - 2: R/W1C  {23'b0, pending[8:0]}. A write clears each pending bit whose DIn bit is 1.
  - 3: R/W  {23'b0, ien[8:0]}, interrupt enable mask; a write loads DIn[8:0].
  - 4-7: read 0, writes ignored.
  - Writes to indices 0 and 1 are ignored.
- Simultaneous set and W1C on the same pending bit in the same cycle: set wins, bit stays 1.
- irq = |(pending & ien), combinational from registers. It drops in the cycle after the clearing write.
- Reset asserted mid-debounce discards all partial samples. After release, stable values re-qualify from zero; a key held through reset produces a press edge once it qualifies.

Optional Feature:
- Macro: SW_CHANGE_IRQ_EN.
- Defined:
  - pending[8] is set in any cycle where stable_sw differs from its previous-cycle value.
  - W1C via DIn[8]; gated by ien[8]; set-wins rule applies.
- Undefined:
  - pending[8] and ien[8] are constant 0 and read 0; DIn[8] writes are ignored.
  - No switch-change storage or comparator is present.

Test Plan (DEB_CYCLES=4):
- Hold reset=0, drive sw_n=32'h0000_FFFF, key=8'hFF -> RD=0 at every Addr, irq=0. Release reset, wait 20 cycles -> Addr0 reads 32'hFFFF_0000; Addr1 reads 8'hFF; Addr2 reads 8'hFF.
- After reset, drive key[3] 0->1 and hold; write Addr3=9'h008 -> within 11 cycles Addr1=8'h08, Addr2=9'h008, irq=1. Write Addr2 DIn=9'h008 -> next cycle Addr2=0, irq=0; releasing key[3] sets no pending.
- Pulse key[0]=1 for 2 cycles only -> stable_key never changes, pending stays 0, irq stays 0.
- Force a key[1] press edge in the same cycle as a W1C write of DIn=9'h002 -> pending[1] reads 1 afterwards.
- With SW_CHANGE_IRQ_EN defined and ien=9'h100, toggle sw_n[5] 1->0 -> Addr0 bit5=1, pending[8]=1, irq=1. Without the macro: Addr2 bit8=0, irq stays 0.
- Assert reset=0 for 1 cycle while a key is qualifying -> all registers read 0 immediately. Addr4-7 read 0 in all conditions.

Source files
------------

// File: rtl/driver_switch_if.sv
// rtl/driver_switch_if.sv - CPU word-select bus between the bridge and the switch/key input driver
interface driver_switch_if;
    logic [31:0] DIn;
    logic        WE;
    logic [2:0]  Addr;
    logic [31:0] RD;
    logic        irq;

    modport master (output DIn, WE, Addr, input RD, irq);
    modport slave  (input DIn, WE, Addr, output RD, irq);
endinterface

// File: rtl/driver_switch.sv
// rtl/driver_switch.sv - DIP switch / user key input driver: sync, debounce, key-press pending + irq
// Optional switch-change interrupt on pending[8]/ien[8] is built when SW_CHANGE_IRQ_EN is defined.
module driver_switch #(
    parameter int DEB_CYCLES = 200000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       sw_n,
    input  logic [7:0]        key,
    driver_switch_if.slave    bus
);

    localparam int              CNT_W    = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             tick;

    logic [39:0] sync_q1;
    logic [39:0] sync_q2;
    logic [39:0] in_sync;
    logic [39:0] samp;
    logic [39:0] stable;
    logic [39:0] diff;

    logic [31:0] stable_sw;
    logic [7:0]  stable_key;
    logic [7:0]  prev_key;
    logic [7:0]  key_rise;
    logic [7:0]  pending_key;
    logic [7:0]  ien_key;
    logic        pend_sw;
    logic        ien_sw;
    logic [8:0]  pending_w;
    logic [8:0]  ien_w;

    logic        wr_pend;
    logic        wr_ien;

    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Switches are stored raw and inverted after the second flop, so stored 1 = switch on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {key, sw_n};
            sync_q2 <= sync_q1;
        end
    end

    assign in_sync = {sync_q2[39:32], ~sync_q2[31:0]};
    assign diff    = in_sync ^ samp;

    // A bit qualifies only when it reads the same on two consecutive ticks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            samp   <= '0;
            stable <= '0;
        end else if (tick) begin
            samp   <= in_sync;
            stable <= (stable & diff) | (in_sync & ~diff);
        end
    end

    assign stable_sw  = stable[31:0];
    assign stable_key = stable[39:32];
    assign key_rise   = stable_key & ~prev_key;

    assign wr_pend = bus.WE && (bus.Addr == 3'd2);
    assign wr_ien  = bus.WE && (bus.Addr == 3'd3);

    // The set term is OR-ed after the W1C mask, so a same-cycle press survives the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_key    <= '0;
            pending_key <= '0;
            ien_key     <= '0;
        end else begin
            prev_key    <= stable_key;
            pending_key <= (pending_key & ~(wr_pend ? bus.DIn[7:0] : 8'h00)) | key_rise;
            if (wr_ien) begin
                ien_key <= bus.DIn[7:0];
            end
        end
    end

`ifdef SW_CHANGE_IRQ_EN
    logic [31:0] prev_sw;
    logic        sw_change;
    logic [22:0] unused_din;

    assign sw_change  = |(stable_sw ^ prev_sw);
    assign unused_din = bus.DIn[31:9];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_sw <= '0;
            pend_sw <= 1'b0;
            ien_sw  <= 1'b0;
        end else begin
            prev_sw <= stable_sw;
            pend_sw <= (pend_sw & ~(wr_pend & bus.DIn[8])) | sw_change;
            if (wr_ien) begin
                ien_sw <= bus.DIn[8];
            end
        end
    end
`else
    logic [23:0] unused_din;

    assign unused_din = bus.DIn[31:8];
    assign pend_sw    = 1'b0;
    assign ien_sw     = 1'b0;
`endif

    assign pending_w = {pend_sw, pending_key};
    assign ien_w     = {ien_sw, ien_key};

    always_comb begin
        bus.RD = 32'h0;
        case (bus.Addr)
            3'd0:    bus.RD = stable_sw;
            3'd1:    bus.RD = {24'h0, stable_key};
            3'd2:    bus.RD = {23'h0, pending_w};
            3'd3:    bus.RD = {23'h0, ien_w};
            default: bus.RD = 32'h0;
        endcase
    end

    assign bus.irq = |(pending_w & ien_w);

endmodule

// File: tb/tb_driver_switch.sv
// tb/tb_driver_switch.sv - scoreboard bench for driver_switch with DEB_CYCLES=4
module tb_driver_switch;

    localparam int DEB = 4;

`ifdef SW_CHANGE_IRQ_EN
    localparam logic [31:0] P8  = 32'h100;
    localparam logic        SWI = 1'b1;
`else
    localparam logic [31:0] P8  = 32'h000;
    localparam logic        SWI = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] sw_n;
    logic [7:0]  key;

    driver_switch_if bus();

    driver_switch #(.DEB_CYCLES(DEB)) dut (
        .clk   (clk),
        .reset (reset),
        .sw_n  (sw_n),
        .key   (key),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    string       q_name[$];
    logic [31:0] q_rd[$];
    logic        q_irq[$];

    always @(negedge clk) begin
        if (q_rd.size() > 0) begin
            string       n;
            logic [31:0] r;
            logic        i;
            n = q_name.pop_front();
            r = q_rd.pop_front();
            i = q_irq.pop_front();
            total++;
            if (bus.RD !== r || bus.irq !== i) begin
                bad++;
                $display("FAIL %s: addr=%0d got RD=%h irq=%b, want RD=%h irq=%b",
                         n, bus.Addr, bus.RD, bus.irq, r, i);
            end
        end
    end

    task automatic sample(input string n, input logic [2:0] a, input logic [31:0] r, input logic i);
        bus.Addr = a;
        q_name.push_back(n);
        q_rd.push_back(r);
        q_irq.push_back(i);
        @(negedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.Addr = a;
        bus.DIn  = d;
        bus.WE   = 1'b1;
        @(posedge clk);
        #1;
        bus.WE   = 1'b0;
    endtask

    task automatic wait_bit(input string n, input logic [2:0] a, input int b, input int limit);
        logic found;
        found    = 1'b0;
        bus.Addr = a;
        for (int k = 0; k < limit; k++) begin
            @(posedge clk);
            #1;
            if (bus.RD[b] === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL %s: bit %0d of addr %0d still 0 after %0d cycles, want 1", n, b, a, limit);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic found;
        bus.DIn  = '0;
        bus.WE   = 1'b0;
        bus.Addr = '0;
        sw_n     = 32'h0000_FFFF;
        key      = 8'hFF;
        #2;
        reset = 1'b0;
        cycles(2);

        for (int a = 0; a < 8; a++) sample("reset_rd", 3'(a), 32'h0, 1'b0);

        reset = 1'b1;
        cycles(20);
        sample("sw_init",   3'd0, 32'hFFFF_0000, 1'b0);
        sample("key_init",  3'd1, 32'h0000_00FF, 1'b0);
        sample("pend_init", 3'd2, 32'h0FF | P8,  1'b0);
        sample("ien_init",  3'd3, 32'h0,         1'b0);

        key = 8'h00;
        cycles(20);
        sample("key_release",   3'd1, 32'h0,        1'b0);
        sample("pend_keep_rel", 3'd2, 32'h0FF | P8, 1'b0);
        wr(3'd2, 32'h1FF);
        sample("pend_clear_all", 3'd2, 32'h0, 1'b0);

        wr(3'd3, 32'h008);
        sample("ien_write", 3'd3, 32'h008, 1'b0);
        key[3] = 1'b1;
        wait_bit("key3_latency", 3'd1, 3, 11);
        cycles(1);
        sample("key3_stable", 3'd1, 32'h08, 1'b1);
        sample("key3_pend",   3'd2, 32'h08, 1'b1);
        wr(3'd2, 32'h008);
        sample("key3_w1c", 3'd2, 32'h0, 1'b0);
        key[3] = 1'b0;
        cycles(20);
        sample("key3_rel_key",  3'd1, 32'h0, 1'b0);
        sample("key3_rel_pend", 3'd2, 32'h0, 1'b0);

        key[0] = 1'b1;
        cycles(2);
        key[0] = 1'b0;
        cycles(20);
        sample("glitch_key",  3'd1, 32'h0, 1'b0);
        sample("glitch_pend", 3'd2, 32'h0, 1'b0);

        key[1]   = 1'b1;
        bus.Addr = 3'd1;
        found    = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.RD[1] === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (found) begin
            wr(3'd2, 32'h002);
            sample("set_wins", 3'd2, 32'h002, 1'b0);
        end else begin
            total++;
            bad++;
            $display("FAIL set_wins_sync: key1 never qualified in 12 cycles, want qualified");
        end
        wr(3'd2, 32'h002);
        sample("key1_w1c", 3'd2, 32'h0, 1'b0);

        wr(3'd3, 32'h108);
        sample("ien_sw_bit", 3'd3, 32'h008 | P8, 1'b0);
        sw_n[5] = 1'b0;
        wait_bit("sw5_latency", 3'd0, 5, 11);
        cycles(1);
        sample("sw5_rd",   3'd0, 32'hFFFF_0020, SWI);
        sample("sw5_pend", 3'd2, P8,            SWI);
        wr(3'd2, 32'h1FF);
        sample("sw5_w1c", 3'd2, 32'h0, 1'b0);

        wr(3'd0, 32'h0);
        wr(3'd1, 32'h0);
        wr(3'd5, 32'hFFFF_FFFF);
        sample("wr0_ignored", 3'd0, 32'hFFFF_0020, 1'b0);
        sample("wr1_ignored", 3'd1, 32'h02,        1'b0);
        for (int a = 4; a < 8; a++) sample("hi_addr_zero", 3'(a), 32'h0, 1'b0);

        key[2] = 1'b1;
        cycles(5);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) sample("reset_mid", 3'(a), 32'h0, 1'b0);
        reset = 1'b1;
        cycles(20);
        sample("post_rst_sw",   3'd0, 32'hFFFF_0020, 1'b0);
        sample("post_rst_key",  3'd1, 32'h06,        1'b0);
        sample("post_rst_pend", 3'd2, 32'h006 | P8,  1'b0);
        sample("post_rst_ien",  3'd3, 32'h0,         1'b0);
        wr(3'd3, 32'h004);
        sample("post_rst_irq",  3'd2, 32'h006 | P8,  1'b1);
        for (int a = 4; a < 8; a++) sample("hi_addr_zero2", 3'(a), 32'h0, 1'b1);

        cycles(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
